// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-boundary registers: stage FSM states and
// the control bundles carried across each boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // ID/EX: everything decode produces for the back end
    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } id_ex_ctrl_t;

    // EX/MEM: ALU controls consumed, memory and writeback remain
    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ex_mem_ctrl_t;

    // MEM/WB: reg_write sits in bit 0
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } mem_wb_ctrl_t;

    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready link between two pipeline stages. The producer uses the
// master modport, the consumer uses the slave modport.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One storage slot: valid flag plus ctrl/data. Clear beats load; a clear
// keeps the data so the payload holds its last value while empty.
module pipe_slot #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              ld,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    // slot register with priority reset > clear > load
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (ld) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready flow control, flush and an
// optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_stage_reg #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 64,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_reg_if.slave   up,
    pipe_stage_reg_if.master  dn,
    output logic [1:0]        occupancy
);
    import pipe_pkg::*;

    logic              main_v, main_ld, main_clr;
    logic [CTRL_W-1:0] main_ctrl, ld_ctrl;
    logic [DATA_W-1:0] main_data, ld_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .reset  (reset),
        .clr    (main_clr),
        .ld     (main_ld),
        .d_ctrl (ld_ctrl),
        .d_data (ld_data),
        .valid  (main_v),
        .ctrl   (main_ctrl),
        .data   (main_data)
    );

    // the main slot always drives the outputs; a bubble never carries control
    assign dn.valid = main_v;
    assign dn.ctrl  = main_v ? main_ctrl : '0;
    assign dn.data  = main_data;

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_e       state_q, state_n;
            logic              rdy_q;
            logic              skid_v, skid_ld, skid_clr, from_skid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk    (clk),
                .reset  (reset),
                .clr    (skid_clr),
                .ld     (skid_ld),
                .d_ctrl (up.ctrl),
                .d_data (up.data),
                .valid  (skid_v),
                .ctrl   (skid_ctrl),
                .data   (skid_data)
            );

            // next state and slot controls; flush empties both slots
            always_comb begin
                state_n   = state_q;
                main_ld   = 1'b0;
                main_clr  = 1'b0;
                skid_ld   = 1'b0;
                skid_clr  = 1'b0;
                from_skid = 1'b0;
                if (flush) begin
                    state_n  = pipe_pkg::EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end else begin
                    case (state_q)
                        pipe_pkg::EMPTY: begin
                            if (up.valid) begin
                                main_ld = 1'b1;
                                state_n = pipe_pkg::FULL;
                            end
                        end
                        pipe_pkg::FULL: begin
                            if (up.valid && dn.ready) begin
                                main_ld = 1'b1;
                            end else if (!up.valid && dn.ready) begin
                                main_clr = 1'b1;
                                state_n  = pipe_pkg::EMPTY;
                            end else if (up.valid && !dn.ready) begin
                                skid_ld = 1'b1;
                                state_n = pipe_pkg::SKID;
                            end
                        end
                        pipe_pkg::SKID: begin
                            if (dn.ready) begin
                                main_ld   = 1'b1;
                                from_skid = 1'b1;
                                skid_clr  = 1'b1;
                                state_n   = pipe_pkg::FULL;
                            end
                        end
                        default: state_n = pipe_pkg::EMPTY;
                    endcase
                end
            end

            // state and registered in_ready, derived from the next state
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= pipe_pkg::EMPTY;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_n;
                    rdy_q   <= (state_n != pipe_pkg::SKID);
                end
            end

            assign ld_ctrl   = from_skid ? skid_ctrl : up.ctrl;
            assign ld_data   = from_skid ? skid_data : up.data;
            assign up.ready  = rdy_q;
            assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
        end else begin : g_single
            logic xfer_in, xfer_out;

            assign up.ready  = !main_v || dn.ready;
            assign xfer_in   = up.valid && up.ready;
            assign xfer_out  = main_v && dn.ready;
            assign main_ld   = xfer_in && !flush;
            assign main_clr  = flush || (xfer_out && !xfer_in);
            assign ld_ctrl   = up.ctrl;
            assign ld_data   = up.data;
            assign occupancy = {1'b0, main_v};
        end
    endgenerate

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register with valid/ready flow control, synchronous flush and an optional 2-entry skid buffer.
- Carries a control bundle (e.g. MEM/WB reg_write, mem_to_reg) and a data payload between adjacent stages.
- Replaces the per-stage fixed control registers; one instance per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- CTRL_W, 2, width of control bundle; bits forced to 0 whenever the stage holds a bubble.
- DATA_W, 64, width of data payload (ALU result, mem data, rd index, ...).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming entries at the next edge.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts the entry.
- out_ctrl  out  CTRL_W  control bundle; 0 when out_valid=0.
- out_data  out  DATA_W  payload; holds its last value when out_valid=0 (don't-care).
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Handshake: transfer_in = in_valid & in_ready; transfer_out = out_valid & out_ready. Latency is 1 cycle from an accepted input to out_valid.
- Once asserted, out_valid stays high with stable out_ctrl/out_data until transfer_out or flush.
- Reset (and priority order reset > flush > normal): out_valid=0, out_ctrl=0, occupancy=0, state EMPTY, in_ready=1 after the reset cycle. out_data resets to 0.
- SKID=1 state machine (main slot drives the outputs; skid slot holds the overflow entry):
  - EMPTY: in_ready=1. in_valid -> FULL (load main); else stay.
  - FULL, in_valid & out_ready: stay FULL, reload main.
  - FULL, !in_valid & out_ready: -> EMPTY.
  - FULL, in_valid & !out_ready: -> SKID (load skid).
  - FULL, neither: stay.
  - SKID: in_ready=0, so in_valid is ignored. out_ready -> FULL with main <= skid; else stay.
  - in_ready is a flop: it equals (state != SKID) and has no combinational path from out_ready.
- SKID=0: a single slot with in_ready = !out_valid | out_ready (combinational).
  - transfer_in loads the slot; transfer_out without transfer_in empties it.
- Flush:
  - At the next edge, every slot becomes invalid and the state goes to EMPTY. An input accepted in the flush cycle is dropped.
  - A transfer_out in the flush cycle still completes; downstream owns that decision.
  - in_ready=1 in the cycle after the flush.
- Bubble gating: out_ctrl = out_valid ? main_ctrl : 0, so a bubble can never assert reg_write.
- occupancy: EMPTY=0, FULL=1, SKID=2.
- Reset or flush mid-stall (state SKID): both entries are discarded and no entry reappears afterwards.

Decomposition:
- pipe_pkg holds:
  - typedef enum pipe_state_e {EMPTY, FULL, SKID}.
  - mem_wb_ctrl_t packed struct {mem_to_reg, reg_write}, with reg_write as bit 0.
  - Constant MEM_WB_CTRL_W=2, plus equivalent ctrl structs and widths for the other stage boundaries.
- Sub-module pipe_slot: valid + ctrl + data register with load and clear enables. Instantiated once (SKID=0) or twice (main, skid).

Test Plan:
- Reset mid-stream: reset high 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0; in_ready=1 on the first cycle after reset.
- Streaming (SKID=1, out_ready=1): inputs ctrl=2'b01, data=0x10, 0x11, 0x12 on consecutive cycles -> the same sequence on out_* one cycle later, with no gaps and in_ready always 1.
- Back-pressure (SKID=1): input 0xA0 accepted, then out_ready=0 while 0xA1 is offered -> occupancy=2 and in_ready=0 next cycle. Raise out_ready -> output order 0xA0, 0xA1, with nothing lost or duplicated.
- Flush while in SKID: entries 0xB0 and 0xB1 held, flush=1 and in_valid=1 with 0xB2 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xB2 never appears.
- Bubble gating: in_valid=0 with in_ctrl=2'b11 driven -> out_ctrl stays 2'b00 for 10 cycles.
- SKID=0 variant: out_ready=0 with one entry held -> in_ready=0 in the same cycle. Raising out_ready with in_valid=1 swaps the entry in one cycle, with occupancy staying 1.
